// File: rtl/u_rec_param.sv
// Parametrised UART receiver: synchroniser, oversampled frame FSM with glitch,
// parity, framing and break detection, valid/ready output with sticky overrun.
module u_rec_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_l,
  input  logic                 baud_tickH,
  input  logic                 uart_dataH,
  output logic [DATA_BITS-1:0] rec_dataH,
  output logic                 rec_validH,
  input  logic                 rec_readyH,
  output logic                 parity_errH,
  output logic                 frame_errH,
  output logic                 break_detH,
  output logic                 overrunH,
  input  logic                 err_clrH
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_SLAST = BW'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == 1);

  // state      | meaning
  // IDLE       | line idle, waiting for a low sample
  // START      | confirming the start bit at mid-bit
  // DATA       | shifting in data bits LSB-first
  // PARITY     | sampling the parity bit
  // STOP       | checking stop bits
  // DELIVER    | presenting the word or flagging overrun
  // BREAK_WAIT | line held low after a break, waiting for high
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY_S, STOP, DELIVER, BREAK_WAIT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr;
  logic                   ferr;
  logic                   rxs;

  assign rxs = sync[SYNC_STAGES-1];

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      sync        <= '1;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      rec_dataH   <= '0;
      rec_validH  <= 1'b0;
      parity_errH <= 1'b0;
      frame_errH  <= 1'b0;
      break_detH  <= 1'b0;
      overrunH    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], uart_dataH};

      if (rec_validH && rec_readyH) begin
        rec_validH  <= 1'b0;
        parity_errH <= 1'b0;
        frame_errH  <= 1'b0;
        break_detH  <= 1'b0;
      end
      if (err_clrH) overrunH <= 1'b0;

      // DELIVER assignments come later so a new word or overrun overrides the clears above
      case (state)
        IDLE: begin
          if (baud_tickH && !rxs) begin
            tick_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_tickH) begin
            if (tick_cnt == T_HALF) begin
              if (rxs) begin
                state <= IDLE;
              end else begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
                perr     <= 1'b0;
                ferr     <= 1'b0;
                state    <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (baud_tickH) begin
            if (tick_cnt == T_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rxs, shreg[DATA_BITS-1:1]};
              if (bit_cnt == B_DLAST) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? PARITY_S : STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        PARITY_S: begin
          if (baud_tickH) begin
            if (tick_cnt == T_LAST) begin
              tick_cnt <= '0;
              perr     <= ((^shreg) ^ rxs) != ODD;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        STOP: begin
          if (baud_tickH) begin
            if (tick_cnt == T_LAST) begin
              tick_cnt <= '0;
              if (!rxs) ferr <= 1'b1;
              if (bit_cnt == B_SLAST) begin
                bit_cnt <= '0;
                state   <= DELIVER;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DELIVER: begin
          if (!rec_validH || rec_readyH) begin
            rec_dataH   <= shreg;
            parity_errH <= perr;
            frame_errH  <= ferr;
            break_detH  <= (shreg == '0) && ferr;
            rec_validH  <= 1'b1;
          end else begin
            overrunH <= 1'b1;
          end
          state <= ((shreg == '0) && ferr) ? BREAK_WAIT : IDLE;
        end
        BREAK_WAIT: begin
          if (baud_tickH && rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_u_rec_param.sv
// Directed bench for u_rec_param: three instances (8N1 default, 7E1, 8N2) on a
// shared clock, each with its own line and handshake.
module tb_u_rec_param;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [2:0] tick, line, ready, clr;
  logic [2:0] valid, pe, fe, bd, ov;
  logic [7:0] data0;
  logic [6:0] data1;
  logic [7:0] data2;

  int         npass = 0;
  int         ntotal = 0;
  int         cnt[3] = '{0, 0, 0};
  logic [8:0] last_d[3];
  logic [2:0] last_f[3];

  always #5 clk = ~clk;

  u_rec_param d0 (
    .sys_clk(clk), .sys_rst_l(rst_l), .baud_tickH(tick[0]), .uart_dataH(line[0]),
    .rec_dataH(data0), .rec_validH(valid[0]), .rec_readyH(ready[0]),
    .parity_errH(pe[0]), .frame_errH(fe[0]), .break_detH(bd[0]),
    .overrunH(ov[0]), .err_clrH(clr[0]));

  u_rec_param #(.DATA_BITS(7), .PARITY(2)) d1 (
    .sys_clk(clk), .sys_rst_l(rst_l), .baud_tickH(tick[1]), .uart_dataH(line[1]),
    .rec_dataH(data1), .rec_validH(valid[1]), .rec_readyH(ready[1]),
    .parity_errH(pe[1]), .frame_errH(fe[1]), .break_detH(bd[1]),
    .overrunH(ov[1]), .err_clrH(clr[1]));

  u_rec_param #(.STOP_BITS(2)) d2 (
    .sys_clk(clk), .sys_rst_l(rst_l), .baud_tickH(tick[2]), .uart_dataH(line[2]),
    .rec_dataH(data2), .rec_validH(valid[2]), .rec_readyH(ready[2]),
    .parity_errH(pe[2]), .frame_errH(fe[2]), .break_detH(bd[2]),
    .overrunH(ov[2]), .err_clrH(clr[2]));

  // Record every accepted word; flags packed as {break, frame, parity}
  always @(posedge clk) begin
    if (valid[0] && ready[0]) begin
      cnt[0] <= cnt[0] + 1; last_d[0] <= {1'b0, data0}; last_f[0] <= {bd[0], fe[0], pe[0]};
    end
    if (valid[1] && ready[1]) begin
      cnt[1] <= cnt[1] + 1; last_d[1] <= {2'b0, data1}; last_f[1] <= {bd[1], fe[1], pe[1]};
    end
    if (valid[2] && ready[2]) begin
      cnt[2] <= cnt[2] + 1; last_d[2] <= {1'b0, data2}; last_f[2] <= {bd[2], fe[2], pe[2]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Frame bits LSB first, 16 clocks each; abort_bit >= 0 pulses reset mid-bit and stops
  task automatic send(input int k, input logic [15:0] frame, input int len, input int abort_bit);
    for (int b = 0; b < len; b++) begin
      line[k] = frame[b];
      if (b == abort_bit) begin
        repeat (8) @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l   = 1'b1;
        line[k] = 1'b1;
        return;
      end
      repeat (16) @(negedge clk);
    end
    line[k] = 1'b1;
  endtask

  task automatic wait_words(input int k, input int n);
    for (int i = 0; i < 400 && cnt[k] < n; i++) @(negedge clk);
    check("word_arrived", cnt[k], n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_l = 1'b0;
    tick  = 3'b111;
    line  = 3'b111;
    ready = 3'b111;
    clr   = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_valid", {29'b0, valid}, 0);
    check("rst_data0", data0, 0);
    check("rst_flags", {pe, fe, bd, ov}, 0);
    rst_l = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0xA5
    send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1);
    wait_words(0, 1);
    check("a5_data", last_d[0], 9'h0A5);
    check("a5_flags", last_f[0], 3'b000);
    repeat (20) @(negedge clk);
    check("a5_one_pulse", cnt[0], 1);
    check("a5_valid_low", valid[0], 1'b0);

    // Low glitch shorter than half a bit
    line[0] = 1'b0;
    repeat (6) @(negedge clk);
    line[0] = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_word", cnt[0], 1);
    check("glitch_valid", valid[0], 1'b0);

    // 7E1: 0x41 has even ones, so parity bit 1 is wrong and 0 is right
    send(1, {6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, -1);
    wait_words(1, 1);
    check("par_bad_data", last_d[1], 9'h041);
    check("par_bad_flags", last_f[1], 3'b001);
    send(1, {6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10, -1);
    wait_words(1, 2);
    check("par_ok_data", last_d[1], 9'h041);
    check("par_ok_flags", last_f[1], 3'b000);

    // 8N2: second stop bit low, then a held-low break
    send(2, {5'b0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11, -1);
    wait_words(2, 1);
    check("ferr_data", last_d[2], 9'h03C);
    check("ferr_flags", last_f[2], 3'b010);
    repeat (40) @(negedge clk);
    line[2] = 1'b0;
    repeat (528) @(negedge clk);
    check("break_one_word", cnt[2], 2);
    check("break_data", last_d[2], 9'h000);
    check("break_flags", last_f[2], 3'b110);
    line[2] = 1'b1;
    repeat (100) @(negedge clk);
    check("break_no_repeat", cnt[2], 2);
    send(2, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, -1);
    wait_words(2, 3);
    check("after_break_data", last_d[2], 9'h03C);
    check("after_break_flags", last_f[2], 3'b000);

    // Overrun: hold the first word, second frame is discarded
    ready[0] = 1'b0;
    send(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, -1);
    send(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, -1);
    repeat (5) @(negedge clk);
    check("ovr_valid", valid[0], 1'b1);
    check("ovr_data_held", data0, 8'h11);
    check("ovr_flag", ov[0], 1'b1);
    ready[0] = 1'b1;
    @(negedge clk);
    check("ovr_accept_valid", valid[0], 1'b0);
    check("ovr_accept_data", last_d[0], 9'h011);
    check("ovr_sticky", ov[0], 1'b1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    check("ovr_cleared", ov[0], 1'b0);

    // Reset during data bit 4 of 0x5A
    send(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 5);
    repeat (3) @(negedge clk);
    check("midrst_data", data0, 8'h00);
    check("midrst_outs", {valid[0], pe[0], fe[0], bd[0], ov[0]}, 5'b0);
    repeat (300) @(negedge clk);
    check("midrst_no_word", cnt[0], 2);
    send(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, -1);
    wait_words(0, 3);
    check("post_rst_data", last_d[0], 9'h05A);
    check("post_rst_flags", last_f[0], 3'b000);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
